instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Instruction fetch stage of the 5-stage MIPS pipeline, producing the PC/IR pair consumed by instruction decode. Issues sequential word fetches to instruction memory over a req/ack handshake with variable latency. Buffers returned words in a small prefetch FIFO, presents them to decode with valid/ready stall control, and flushes on a jump/branch redirect, discarding any in-flight response.

## Interface
- DEPTH, 4, prefetch FIFO entries (power of two, ≥2)
- RESET_PC, 32'h0000_0000, first fetch address after reset

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- imem_req  out  1  fetch request; held high until ack
- imem_addr  out  32  word address of request; stable while imem_req=1
- imem_ack  in  1  response strobe; imem_rdata valid this cycle
- imem_rdata  in  32  instruction word
- redirect  in  1  jump/branch taken; flush and refetch
- redirect_pc  in  32  new fetch target; bits [1:0] forced to 0
- fd_valid  out  1  PC/IR valid to decode
- fd_ready  in  1  decode accepts PC/IR this cycle
- PC  out  32  address of head instruction
- IR  out  32  head instruction word

## Operation
- Single outstanding request. FSM states IDLE, REQ, DISCARD; registered fetch_pc.
- IDLE: imem_req=0. Next REQ if count<DEPTH, else stay.
- REQ: imem_req=1, imem_addr=fetch_pc.
  - ack, no redirect: push {fetch_pc, imem_rdata}; fetch_pc+=4; next REQ if post-update count<DEPTH, else IDLE.
  - redirect, no ack: flush; next DISCARD; fetch_pc=redirect_pc; imem_addr keeps old address.
  - redirect with ack: data dropped; flush; fetch_pc=redirect_pc; next REQ (new address next cycle).
- DISCARD: imem_req=1 with old address until ack; response dropped; then REQ at fetch_pc. Another redirect in DISCARD only overwrites fetch_pc.
- Pop: fd_valid & fd_ready removes head. Push and pop in same cycle allowed; count unchanged.
- Redirect overrides pop and push: FIFO empties next cycle regardless.
- fd_valid = (count!=0). PC/IR = head entry; 0 when empty.
- fetch_pc+4 wraps mod 2^32 (32'hFFFF_FFFC -> 0).

## Timing
- Reset values: imem_req 0, imem_addr RESET_PC, fd_valid 0, PC 0, IR 0, state IDLE, count 0, fetch_pc RESET_PC.
- First imem_req: cycle after rst deasserts (IDLE->REQ); ack permitted the same cycle as req.
- Ack at cycle t -> fd_valid/PC/IR visible at t+1.
- Zero-wait memory, fd_ready=1: one instruction per cycle sustained.
- Redirect at t: fd_valid=0 at t+1; first redirected request at t+1 (REQ) or cycle after discarded ack (DISCARD).
- rst mid-transaction: immediate return to reset values; pending ack after reset ignored (state IDLE).
- Full FIFO: no request issued; request already accepted always lands (space reserved at issue).

## Structure
- Shared pipeline package: NOP encoding 32'h0, RESET_PC default, fetch FSM state enum, word size constant 4.
- Sub-module fetch_fifo: DEPTH x 64-bit {PC, IR}, push/pop/flush, count, head output; sync to clk, async rst.
- Top holds FSM, fetch_pc, handshake and redirect logic.

## Test plan
- Reset, ack same cycle as req, fd_ready=1 -> PC 0,4,8,12 on consecutive cycles from cycle 2; IR matches memory.
- fd_ready=0, zero-wait memory -> exactly 4 pushes, imem_req drops to 0, PC stays 0; fd_ready=1 -> fetch resumes at 16.
- Redirect to 32'h100 while request for 8 waits 3 cycles for ack -> req/addr hold 8 until ack, data dropped, next request 32'h100, no stale IR reaches decode.
- Redirect and ack in same cycle, redirect_pc 32'h203 -> ack data discarded, next imem_addr 32'h200, fd_valid low one cycle.
- fetch_pc 32'hFFFF_FFFC fetched -> next imem_addr 0.
- rst asserted during outstanding request with FIFO holding 2 entries -> all outputs reset values immediately; after release first imem_addr RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// ============================================================================
//  Module   : instruction_fetch_pkg
//  Brief    : Shared pipeline constants and types for the fetch stage.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package instruction_fetch_pkg;

    localparam logic [31:0] c_nop        = 32'h0000_0000;
    localparam logic [31:0] c_reset_pc   = 32'h0000_0000;
    localparam logic [31:0] c_word_bytes = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } fd_entry_t;

    // Sequential word address; wraps naturally at 2^32.
    function automatic logic [31:0] next_word_addr(input logic [31:0] addr);
        return addr + c_word_bytes;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
//  Module   : fetch_fifo
//  Brief    : Prefetch FIFO of {PC, IR} pairs with push, pop and flush.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_fifo
    import instruction_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  fd_entry_t                  wdata,
    output logic [$clog2(DEPTH):0]     count,
    output fd_entry_t                  head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] c_depth = CW'(DEPTH);

    fd_entry_t       r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_do_push;
    logic            w_do_pop;

    // Flush wins over both push and pop so the FIFO is empty next cycle.
    assign w_do_push = push & ~flush & (r_count != c_depth);
    assign w_do_pop  = pop  & ~flush & (r_count != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= wdata;
    end

    assign count = r_count;
    assign head  = (r_count != '0) ? r_mem[r_rd_ptr] : '{pc: 32'h0, ir: c_nop};

endmodule

`default_nettype wire

// File: rtl/instruction_fetch.sv
// ============================================================================
//  Module   : instruction_fetch
//  Brief    : MIPS IF stage - single-outstanding imem fetch, prefetch FIFO,
//             redirect flush with in-flight response discard.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = c_reset_pc
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        fd_valid,
    input  logic        fd_ready,
    output logic [31:0] PC,
    output logic [31:0] IR
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] c_depth = CW'(DEPTH);

    fetch_state_t   r_state;
    fetch_state_t   w_next_state;
    logic [31:0]    r_fetch_pc;
    logic [31:0]    w_next_fetch_pc;
    logic [31:0]    r_req_addr;
    logic [31:0]    w_redirect_target;
    logic [CW-1:0]  w_count;
    logic [CW-1:0]  w_count_post;
    logic           w_push;
    logic           w_pop;
    logic           w_flush;
    fd_entry_t      w_head;
    fd_entry_t      w_wdata;

    assign w_redirect_target = redirect_pc & ~32'h0000_0003;
    assign w_pop             = fd_valid & fd_ready;
    assign w_count_post      = w_count + CW'(1) - CW'(w_pop);
    assign w_wdata           = '{pc: r_fetch_pc, ir: imem_rdata};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_fetch_pc <= RESET_PC;
            r_req_addr <= RESET_PC;
        end else begin
            r_state    <= w_next_state;
            r_fetch_pc <= w_next_fetch_pc;
            // Remember the issued address so DISCARD can keep presenting it.
            if (r_state == ST_REQ) r_req_addr <= r_fetch_pc;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_next_fetch_pc = r_fetch_pc;
        w_push          = 1'b0;
        w_flush         = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (redirect) begin
                    w_flush         = 1'b1;
                    w_next_fetch_pc = w_redirect_target;
                    w_next_state    = ST_REQ;
                end else if (w_count < c_depth) begin
                    w_next_state = ST_REQ;
                end
            end
            ST_REQ: begin
                if (redirect) begin
                    w_flush         = 1'b1;
                    w_next_fetch_pc = w_redirect_target;
                    w_next_state    = imem_ack ? ST_REQ : ST_DISCARD;
                end else if (imem_ack) begin
                    // Space was reserved when the request was issued.
                    w_push          = 1'b1;
                    w_next_fetch_pc = next_word_addr(r_fetch_pc);
                    w_next_state    = (w_count_post < c_depth) ? ST_REQ : ST_IDLE;
                end
            end
            ST_DISCARD: begin
                if (redirect) begin
                    w_flush         = 1'b1;
                    w_next_fetch_pc = w_redirect_target;
                end
                if (imem_ack) w_next_state = ST_REQ;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fetch_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .flush (w_flush),
        .wdata (w_wdata),
        .count (w_count),
        .head  (w_head)
    );

    assign imem_req  = (r_state != ST_IDLE);
    assign imem_addr = (r_state == ST_DISCARD) ? r_req_addr : r_fetch_pc;
    assign fd_valid  = (w_count != '0);
    assign PC        = w_head.pc;
    assign IR        = w_head.ir;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
// ============================================================================
//  Module   : tb_instruction_fetch
//  Brief    : Directed scoreboard bench for the instruction fetch stage.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        fd_valid;
    logic        fd_ready = 1'b0;
    logic [31:0] PC;
    logic [31:0] IR;

    int          n_vec = 0;
    int          n_bad = 0;
    int          n_acc = 0;
    int          lat   = 0;
    int          wcnt  = 0;
    logic [63:0] exp_q [$];
    logic [63:0] mon_e;

    always #5 clk = ~clk;

    instruction_fetch #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fd_valid    (fd_valid),
        .fd_ready    (fd_ready),
        .PC          (PC),
        .IR          (IR)
    );

    // Memory contents: an lw-style opcode tagged with the word index.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {8'h8C, a[25:2]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pc(input logic [31:0] a);
        exp_q.push_back({a, mem_word(a)});
    endtask

    task automatic do_reset();
        chk("leftover_expected", exp_q.size(), 0);
        exp_q.delete();
        rst      = 1'b1;
        fd_ready = 1'b0;
        redirect = 1'b0;
        tick();
        tick();
        n_acc = 0;
        rst   = 1'b0;
    endtask

    task automatic wait_acc(input int n, input int budget);
        for (int i = 0; i < budget && n_acc < n; i++) tick();
        chk("accept_count", n_acc, n);
    endtask

    // Memory responder: acks after 'lat' wait cycles, same cycle when lat=0.
    always begin
        @(posedge clk);
        #1;
        if (imem_req && !rst) begin
            if (wcnt >= lat) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
                wcnt       = 0;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = 32'hDEAD_BEEF;
                wcnt++;
            end
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = 32'hDEAD_BEEF;
            wcnt       = 0;
        end
    end

    // Monitor: every PC/IR accepted by decode must match the scoreboard head.
    always @(negedge clk) begin
        if (!rst && fd_valid && fd_ready) begin
            n_acc++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_output: got PC %h IR %h, expected none", PC, IR);
            end else begin
                mon_e = exp_q.pop_front();
                chk("fd_pc", PC, mon_e[63:32]);
                chk("fd_ir", IR, mon_e[31:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        chk("rst_imem_req", imem_req, 0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        chk("rst_fd_valid", fd_valid, 0);
        chk("rst_pc", PC, 32'h0);
        chk("rst_ir", IR, 32'h0);

        // Zero-wait streaming, one instruction per cycle.
        do_reset();
        lat = 0;
        fd_ready = 1'b1;
        expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8); expect_pc(32'hC);
        tick();
        chk("first_req", imem_req, 1);
        chk("first_addr", imem_addr, 32'h0);
        repeat (5) tick();
        fd_ready = 1'b0;
        chk("stream_accepts", n_acc, 4);

        // Decode stalled: FIFO fills to 4, then fetching stops.
        do_reset();
        repeat (5) tick();
        chk("full_req_low", imem_req, 0);
        chk("full_valid", fd_valid, 1);
        chk("full_pc", PC, 32'h0);
        chk("full_ir", IR, mem_word(32'h0));
        repeat (2) tick();
        chk("full_req_still_low", imem_req, 0);
        chk("full_pc_hold", PC, 32'h0);
        expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8); expect_pc(32'hC); expect_pc(32'h10);
        fd_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (imem_req) break;
        end
        chk("resume_addr", imem_addr, 32'h10);
        repeat (3) tick();
        fd_ready = 1'b0;
        chk("resume_accepts", n_acc, 5);

        // Redirect while a slow request for 8 is outstanding.
        do_reset();
        lat = 3;
        fd_ready = 1'b1;
        expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h100);
        repeat (10) tick();
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        chk("discard_valid", fd_valid, 0);
        chk("discard_req", imem_req, 1);
        chk("discard_addr", imem_addr, 32'h8);
        tick();
        chk("discard_addr_hold", imem_addr, 32'h8);
        tick();
        chk("redir_req", imem_req, 1);
        chk("redir_addr", imem_addr, 32'h100);
        wait_acc(3, 20);
        fd_ready = 1'b0;

        // Redirect coinciding with ack; misaligned target.
        do_reset();
        lat = 0;
        fd_ready = 1'b1;
        expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h200);
        repeat (3) tick();
        redirect    = 1'b1;
        redirect_pc = 32'h203;
        tick();
        redirect = 1'b0;
        chk("sameack_addr", imem_addr, 32'h200);
        chk("sameack_valid_low", fd_valid, 0);
        tick();
        chk("sameack_valid_back", fd_valid, 1);
        chk("sameack_pc", PC, 32'h200);
        wait_acc(3, 10);
        fd_ready = 1'b0;

        // Address wrap at the top of memory.
        do_reset();
        fd_ready = 1'b1;
        expect_pc(32'hFFFF_FFFC); expect_pc(32'h0);
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        chk("wrap_top_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_addr", imem_addr, 32'h0);
        wait_acc(2, 10);
        fd_ready = 1'b0;

        // Asynchronous reset with two entries buffered and a request live.
        do_reset();
        repeat (3) tick();
        chk("pre_rst_valid", fd_valid, 1);
        chk("pre_rst_pc", PC, 32'h0);
        rst = 1'b1;
        #1;
        chk("async_req", imem_req, 0);
        chk("async_addr", imem_addr, 32'h0);
        chk("async_valid", fd_valid, 0);
        chk("async_pc", PC, 32'h0);
        chk("async_ir", IR, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_req", imem_req, 1);
        chk("post_rst_addr", imem_addr, 32'h0);
        tick();
        chk("post_rst_pc", PC, 32'h0);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
